// File: rtl/prog_loader_pkg.sv
// Shared types and helpers for the target programming engine.
// State encoding, target mode codes and small decode functions.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET_TGT = 3'd1,
    ST_LOAD      = 3'd2,
    ST_RUN       = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } ldr_state_e;

  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_LOAD = 2'b01;
  localparam logic [1:0] MODE_RUN  = 2'b10;

  function automatic logic [1:0] mode_of(input ldr_state_e s);
    case (s)
      ST_RESET_TGT, ST_LOAD: mode_of = MODE_LOAD;
      ST_RUN:                mode_of = MODE_RUN;
      default:               mode_of = MODE_IDLE;
    endcase
  endfunction

  function automatic logic is_busy(input ldr_state_e s);
    case (s)
      ST_RESET_TGT, ST_LOAD, ST_RUN: is_busy = 1'b1;
      default:                       is_busy = 1'b0;
    endcase
  endfunction

  // Target reset is held only while idle or while the reset pulse is running.
  function automatic logic tgt_released(input ldr_state_e s);
    case (s)
      ST_LOAD, ST_RUN, ST_DONE, ST_ERROR: tgt_released = 1'b1;
      default:                            tgt_released = 1'b0;
    endcase
  endfunction

  function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
    if (len > max_len) begin
      clamp_len = max_len;
    end else begin
      clamp_len = len;
    end
  endfunction

endpackage

// File: rtl/prog_loader_sclk_gen.sv
// Target clock divider. Strobes flag the clk edge on which sclk will rise or fall,
// so registered logic updating on a strobe changes together with sclk.
module sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0] DIV_TOP = DW'(CLK_DIV);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          at_top_s;

  // Counter runs 1..CLK_DIV so the first toggle lands CLK_DIV edges after enable.
  always_comb begin
    at_top_s = (div_q == DIV_TOP);
    div_d    = div_q;
    sclk_d   = sclk_q;
    if (!en_i) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (at_top_s) begin
      div_d  = DW'(1);
      sclk_d = ~sclk_q;
    end else begin
      div_d  = div_q + DW'(1);
      sclk_d = sclk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign rise_stb_o = at_top_s & ~sclk_q;
  assign fall_stb_o = at_top_s & sclk_q;

endmodule

// File: rtl/prog_loader.sv
// Programming engine: resets the target, shifts the stored image out MSB first,
// then lets the target run until it signals completion or times out.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int WORD_W     = 8,
  parameter int DEPTH      = 16,
  parameter int CLK_DIV    = 4,
  parameter int RST_CYCLES = 10,
  parameter int TIMEOUT    = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [WORD_W-1:0]          wr_data,
  input  logic [$clog2(DEPTH+1)-1:0] prog_len,
  input  logic                       start,
  input  logic                       abort,
  output logic                       sclk_out,
  output logic                       rst_n_out,
  output logic                       mosi_out,
  output logic [1:0]                 mode_out,
  input  logic                       done_in,
  output logic                       busy,
  output logic                       finished,
  output logic                       timeout_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int RW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [BW-1:0] BIT_TOP  = BW'(WORD_W - 1);
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_TOP  = TW'(TIMEOUT);

  logic [WORD_W-1:0] img_q [DEPTH];

  ldr_state_e    state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] word_q, word_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          mosi_q, mosi_d;
  logic          rst_n_out_q, rst_n_out_d;
  logic [1:0]    mode_q, mode_d;
  logic          busy_q, busy_d;
  logic          finished_q, finished_d;
  logic          err_q, err_d;
  logic [2:0]    done_sync_q;

  logic sclk_s, rise_stb_s, fall_stb_s;
  logic done_rise_s, last_word_s;

  // The divider is enabled from the next state so sclk drops on the edge that leaves RUN.
  sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (busy_d),
    .sclk_o    (sclk_s),
    .rise_stb_o(rise_stb_s),
    .fall_stb_o(fall_stb_s)
  );

  // Image buffer: writes only land while the engine is not busy.
  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      img_q[wr_addr] <= wr_data;
    end
  end

  // Two-flop synchroniser plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_sync_q <= 3'b000;
    end else begin
      done_sync_q <= {done_sync_q[1:0], done_in};
    end
  end

  assign done_rise_s = done_sync_q[1] & ~done_sync_q[2];
  assign last_word_s = (LW'(word_q) == (len_q - LW'(1)));

  // Sequencer next-state; abort wins over every other input.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    word_d  = word_q;
    bit_d   = bit_q;
    rcnt_d  = rcnt_q;
    tmo_d   = tmo_q;
    mosi_d  = mosi_q;
    if (abort) begin
      state_d = ST_IDLE;
      word_d  = '0;
      bit_d   = '0;
      rcnt_d  = '0;
      tmo_d   = '0;
      mosi_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          mosi_d = 1'b0;
          if (start) begin
            state_d = ST_RESET_TGT;
            len_d   = LW'(clamp_len(32'(prog_len), DEPTH));
            word_d  = '0;
            bit_d   = BIT_TOP;
            rcnt_d  = '0;
            tmo_d   = '0;
          end else begin
            state_d = state_q;
          end
        end
        ST_RESET_TGT: begin
          if (fall_stb_s && (rcnt_q == RST_LAST)) begin
            rcnt_d = '0;
            if (len_q == '0) begin
              state_d = ST_RUN;
              mosi_d  = 1'b0;
            end else begin
              state_d = ST_LOAD;
              mosi_d  = img_q[0][WORD_W-1];
            end
          end else if (fall_stb_s) begin
            rcnt_d = rcnt_q + RW'(1);
          end else begin
            rcnt_d = rcnt_q;
          end
        end
        ST_LOAD: begin
          if (fall_stb_s && (bit_q != '0)) begin
            bit_d  = bit_q - BW'(1);
            mosi_d = img_q[word_q][bit_q - BW'(1)];
          end else if (fall_stb_s && last_word_s) begin
            state_d = ST_RUN;
            mosi_d  = 1'b0;
          end else if (fall_stb_s) begin
            word_d = word_q + AW'(1);
            bit_d  = BIT_TOP;
            mosi_d = img_q[word_q + AW'(1)][WORD_W-1];
          end else begin
            mosi_d = mosi_q;
          end
        end
        ST_RUN: begin
          mosi_d = 1'b0;
          if (done_rise_s) begin
            state_d = ST_DONE;
          end else if (tmo_q == TMO_TOP) begin
            state_d = ST_ERROR;
          end else if (rise_stb_s) begin
            tmo_d = tmo_q + TW'(1);
          end else begin
            tmo_d = tmo_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
          mosi_d  = 1'b0;
        end
      endcase
    end
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    mode_d      = mode_of(state_d);
    busy_d      = is_busy(state_d);
    rst_n_out_d = tgt_released(state_d);
    finished_d  = (state_d == ST_DONE);
    err_d       = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      word_q      <= '0;
      bit_q       <= '0;
      rcnt_q      <= '0;
      tmo_q       <= '0;
      mosi_q      <= 1'b0;
      rst_n_out_q <= 1'b0;
      mode_q      <= MODE_IDLE;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      word_q      <= word_d;
      bit_q       <= bit_d;
      rcnt_q      <= rcnt_d;
      tmo_q       <= tmo_d;
      mosi_q      <= mosi_d;
      rst_n_out_q <= rst_n_out_d;
      mode_q      <= mode_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
      err_q       <= err_d;
    end
  end

  assign sclk_out    = sclk_s;
  assign rst_n_out   = rst_n_out_q;
  assign mosi_out    = mosi_q;
  assign mode_out    = mode_q;
  assign busy        = busy_q;
  assign finished    = finished_q;
  assign timeout_err = err_q;

endmodule

// File: doc/prog_loader.md
# prog_loader

FPGA-demo-side programming engine for the tiny processor. It holds a program image in an internal buffer and brings the target up in a fixed sequence: reset, serial program shift on `mosi_out`, then run until `done_in`. It generates the target clock `sclk_out`, target reset `rst_n_out` and `mode_out`. It supersedes the fixed single-shot driver with these additions:
- parametrised word width, image depth and clock ratio;
- programmable program length;
- run-phase timeout;
- abort;
- restart without system reset.

## Interface
Parameters:
- `WORD_W`, 8: bits per program word, shifted MSB first.
- `DEPTH`, 16: image buffer depth in words.
- `CLK_DIV`, 4: `clk` cycles per `sclk_out` half-period (≥1).
- `RST_CYCLES`, 10: `sclk_out` periods with `rst_n_out` low before loading.
- `TIMEOUT`, 1024: `sclk_out` periods allowed in RUN before error.

Ports:
- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, asynchronous, active-low.
- `wr_en` in 1: image write strobe; ignored while `busy`.
- `wr_addr` in $clog2(DEPTH): image write address.
- `wr_data` in WORD_W: image write data.
- `prog_len` in $clog2(DEPTH+1): words to send; sampled on accepted `start`.
- `start` in 1: begin sequence; accepted in IDLE, DONE and ERROR only.
- `abort` in 1: return to IDLE from any state.
- `sclk_out` out 1: target clock.
- `rst_n_out` out 1: target reset, active-low.
- `mosi_out` out 1: serial program data.
- `mode_out` out 2: target mode. IDLE=2'b00, LOAD=2'b01, RUN=2'b10.
- `done_in` in 1: target completion; asynchronous to `clk`.
- `busy` out 1: high in RESET_TGT, LOAD and RUN.
- `finished` out 1: high in DONE.
- `timeout_err` out 1: high in ERROR.

## Operation
- Reset values: `sclk_out`=0, `rst_n_out`=0, `mosi_out`=0, `mode_out`=IDLE, `busy`=0, `finished`=0, `timeout_err`=0. FSM starts in IDLE; the image buffer contents are not reset.
- FSM states: IDLE, RESET_TGT, LOAD, RUN, DONE, ERROR.
- IDLE / DONE / ERROR:
  - `sclk_out` held 0, `mosi_out` 0, `mode_out` IDLE.
  - `rst_n_out` stays 0 in IDLE. It stays 1 in DONE and ERROR, so the target state can be inspected.
  - `start` → RESET_TGT. The effective length is latched as min(`prog_len`, DEPTH).
- RESET_TGT:
  - `sclk_out` toggles, `rst_n_out`=0, `mode_out`=LOAD.
  - After RST_CYCLES full periods, `rst_n_out` rises on a falling-edge strobe.
  - Next state is LOAD, or RUN if the effective length is 0.
- LOAD:
  - Words 0..len-1 are sent, MSB first, one bit per `sclk_out` period.
  - `mosi_out` updates only on falling-edge strobes; the target samples on the rising edge.
  - The first bit is presented at the same falling strobe at which `rst_n_out` rises.
  - After the last bit's period, the next falling strobe enters RUN.
- RUN:
  - `mode_out`=RUN, `mosi_out`=0, `sclk_out` keeps toggling.
  - `done_in` passes through a 2-flop synchroniser. A synchronised rising edge → DONE.
  - If TIMEOUT rising edges of `sclk_out` pass with no done edge → ERROR.
- `abort`: → IDLE on the next `clk`. It overrides `start` and `done_in` in the same cycle. All outputs take their reset values; the bit, word and timeout counters clear.
- Image writes are accepted in IDLE, DONE and ERROR. A `wr_en` while `busy` is dropped, with no side effect.
- `done_in` already high on entry to RUN does not count; a fresh rising edge is required.

## Timing
- `start` accepted at edge N: `busy`=1 and `sclk_out` is still 0 after edge N. The first `sclk_out` rise occurs at N+CLK_DIV.
- One `sclk_out` period = 2·CLK_DIV `clk` cycles.
- LOAD duration = len·WORD_W periods.
- `done_in` rising → `finished` within 3 `clk` edges: 2 synchroniser edges plus 1 state edge. `sclk_out` goes 0 on that same edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- The timeout counter is $clog2(TIMEOUT+1) bits wide, saturating.

## Structure
- `prog_loader_pkg`: state enum `ldr_state_e`, mode constants `MODE_IDLE/LOAD/RUN`.
- Sub-module `sclk_gen`:
  - Divider with an enable input.
  - Outputs `sclk`, one-cycle `rise_stb` and `fall_stb`.
  - Cleared to 0 when disabled.
- Image buffer: a plain register array inside `prog_loader`.
- Synchroniser: inline, 2 flops.

## Test plan
All scenarios use WORD_W=8, DEPTH=16, CLK_DIV=2, RST_CYCLES=4, TIMEOUT=64.
- Reset: hold `rst_n`=0 mid-LOAD → all outputs at their reset values asynchronously; FSM in IDLE after release.
- Load: write 8'hA5, 8'h3C, 8'hFF to addresses 0–2; `prog_len`=3; pulse `start` → `rst_n_out` low for exactly 4 `sclk_out` periods (16 `clk` cycles). Then 24 rising-edge samples read 10100101 00111100 11111111, with `mode_out`=01 throughout.
- Completion: in RUN, drive `done_in` high asynchronously for 3 `clk` → `finished`=1 within 3 edges, `mode_out`=00, `sclk_out` stays 0. Then `start` with `prog_len`=1 → full resend of 8'hA5.
- Timeout: `done_in` held 0 → `timeout_err`=1 after exactly 64 `sclk_out` rises in RUN. `done_in` already 1 on RUN entry also ends in timeout.
- Abort: assert `abort` at bit 5 of word 1 → IDLE next `clk`, `rst_n_out`=0, `busy`=0. A restart sends again from word 0, bit 7.
- Boundaries:
  - `prog_len`=0 → RESET_TGT then RUN with no LOAD bits.
  - `prog_len`=20 → 128 bits sent (clamped to 16 words).
  - `wr_en` to address 0 during LOAD → image unchanged.
